// File: rtl/hp_int_div_rk.sv
// hp_int_div_rk: iterative restoring divider retiring RADIX_LOG2 quotient bits per cycle, RISC-V DIV/REM incl. *W forms.
// Optional last-result cache is built in when HP_DIV_RESULT_CACHE_EN is defined.
module hp_int_div_rk #(
  parameter int XLEN       = 64,
  parameter int RADIX_LOG2 = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush_i,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  input  logic            signed_en,
  input  logic            word_en,
  output logic [XLEN-1:0] quot_o,
  output logic [XLEN-1:0] rem_o,
  output logic            out_valid,
  input  logic            out_ready
);

  localparam int CNT_W = $clog2(XLEN);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(XLEN / RADIX_LOG2 - 1);
  localparam logic [CNT_W-1:0] CNT_WORD = CNT_W'(32 / RADIX_LOG2 - 1);
  localparam logic [XLEN-1:0]  MIN_FULL = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0]  MIN_WORD = {{(XLEN-31){1'b1}}, 31'b0};

  typedef enum logic [2:0] {IDLE, PREP, ITER, FIX, DONE} state_t;

  function automatic logic [XLEN-1:0] op_ext(input logic [XLEN-1:0] x, input logic sgn,
                                             input logic word);
    if (!word) return x;
    return sgn ? XLEN'($signed(x[31:0])) : XLEN'(x[31:0]);
  endfunction

  function automatic logic [XLEN-1:0] word_fix(input logic [XLEN-1:0] x, input logic word);
    return word ? XLEN'($signed(x[31:0])) : x;
  endfunction

  // RADIX_LOG2 chained restoring steps; returns {partial remainder, shift/quotient register}
  function automatic logic [2*XLEN-1:0] iter_cycle(input logic [XLEN-1:0] prem,
                                                   input logic [XLEN-1:0] sr,
                                                   input logic [XLEN-1:0] dvs);
    logic [XLEN:0]   tr;
    logic [XLEN-1:0] tp;
    logic [XLEN-1:0] ts;
    tp = prem;
    ts = sr;
    for (int i = 0; i < RADIX_LOG2; i++) begin
      tr = {tp, ts[XLEN-1]};
      ts = {ts[XLEN-2:0], 1'b0};
      if (tr >= {1'b0, dvs}) begin
        tr    = tr - {1'b0, dvs};
        ts[0] = 1'b1;
      end
      tp = tr[XLEN-1:0];
    end
    return {tp, ts};
  endfunction

  state_t            state_q, state_d;
  logic [XLEN-1:0]   quot_q, quot_d, rem_q, rem_d;
  logic [XLEN-1:0]   dvd_q, dvd_d, dvs_q, dvs_d;
  logic              sgn_q, sgn_d, word_q, word_d;
  logic              qneg_q, qneg_d, rneg_q, rneg_d;
  logic [XLEN-1:0]   dvs_abs_q, dvs_abs_d;
  logic [XLEN-1:0]   sr_q, sr_d, prem_q, prem_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              dvd_neg, dvs_neg;
  logic [XLEN-1:0]   dvd_abs, dvs_abs;
  logic [2*XLEN-1:0] step;
  logic [XLEN-1:0]   fix_quot, fix_rem;
  logic              is_ovf;

  assign dvd_neg  = sgn_q & dvd_q[XLEN-1];
  assign dvs_neg  = sgn_q & dvs_q[XLEN-1];
  assign dvd_abs  = dvd_neg ? -dvd_q : dvd_q;
  assign dvs_abs  = dvs_neg ? -dvs_q : dvs_q;
  assign is_ovf   = sgn_q && (dvd_q == (word_q ? MIN_WORD : MIN_FULL)) && (dvs_q == '1);
  assign step     = iter_cycle(prem_q, sr_q, dvs_abs_q);
  assign fix_quot = qneg_q ? -sr_q : sr_q;
  assign fix_rem  = rneg_q ? -prem_q : prem_q;

  assign in_ready  = (state_q == IDLE) && !flush_i && !rst;
  assign out_valid = (state_q == DONE);
  assign quot_o    = quot_q;
  assign rem_o     = rem_q;

`ifdef HP_DIV_RESULT_CACHE_EN
  logic            cache_vld_q, cache_vld_d;
  logic [XLEN-1:0] cache_dvd_q, cache_dvd_d, cache_dvs_q, cache_dvs_d;
  logic            cache_sgn_q, cache_sgn_d, cache_word_q, cache_word_d;
  logic [XLEN-1:0] cache_quot_q, cache_quot_d, cache_rem_q, cache_rem_d;
  logic            cache_hit, cache_wr;

  assign cache_hit = cache_vld_q && (cache_dvd_q == dvd_q) && (cache_dvs_q == dvs_q) &&
                     (cache_sgn_q == sgn_q) && (cache_word_q == word_q);
  assign cache_wr  = (state_q == DONE) && out_ready && !flush_i;

  always_comb begin
    cache_vld_d  = cache_vld_q;
    cache_dvd_d  = cache_dvd_q;
    cache_dvs_d  = cache_dvs_q;
    cache_sgn_d  = cache_sgn_q;
    cache_word_d = cache_word_q;
    cache_quot_d = cache_quot_q;
    cache_rem_d  = cache_rem_q;
    if (cache_wr) begin
      cache_vld_d  = 1'b1;
      cache_dvd_d  = dvd_q;
      cache_dvs_d  = dvs_q;
      cache_sgn_d  = sgn_q;
      cache_word_d = word_q;
      cache_quot_d = quot_q;
      cache_rem_d  = rem_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cache_vld_q <= 1'b0;
    else     cache_vld_q <= cache_vld_d;
  end

  always_ff @(posedge clk) begin
    cache_dvd_q  <= cache_dvd_d;
    cache_dvs_q  <= cache_dvs_d;
    cache_sgn_q  <= cache_sgn_d;
    cache_word_q <= cache_word_d;
    cache_quot_q <= cache_quot_d;
    cache_rem_q  <= cache_rem_d;
  end
`endif

  always_comb begin
    state_d   = state_q;
    quot_d    = quot_q;
    rem_d     = rem_q;
    dvd_d     = dvd_q;
    dvs_d     = dvs_q;
    sgn_d     = sgn_q;
    word_d    = word_q;
    qneg_d    = qneg_q;
    rneg_d    = rneg_q;
    dvs_abs_d = dvs_abs_q;
    sr_d      = sr_q;
    prem_d    = prem_q;
    cnt_d     = cnt_q;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          dvd_d   = op_ext(dividend_i, signed_en, word_en);
          dvs_d   = op_ext(divisor_i, signed_en, word_en);
          sgn_d   = signed_en;
          word_d  = word_en;
          state_d = PREP;
        end
      end
      PREP: begin
        qneg_d    = dvd_neg ^ dvs_neg;
        rneg_d    = dvd_neg;
        dvs_abs_d = dvs_abs;
        if (dvs_q == '0) begin
          quot_d  = '1;
          rem_d   = word_fix(dvd_q, word_q);
          state_d = DONE;
        end else if (is_ovf) begin
          quot_d  = word_q ? MIN_WORD : MIN_FULL;
          rem_d   = '0;
          state_d = DONE;
        end
`ifdef HP_DIV_RESULT_CACHE_EN
        else if (cache_hit) begin
          quot_d  = cache_quot_q;
          rem_d   = cache_rem_q;
          state_d = DONE;
        end
`endif
        else begin
          // word operands are left-aligned so the MSB-first walk is the same for both widths
          prem_d  = '0;
          sr_d    = word_q ? (dvd_abs << (XLEN - 32)) : dvd_abs;
          cnt_d   = word_q ? CNT_WORD : CNT_FULL;
          state_d = ITER;
        end
      end
      ITER: begin
        prem_d = step[2*XLEN-1:XLEN];
        sr_d   = step[XLEN-1:0];
        if (cnt_q == '0) state_d = FIX;
        else             cnt_d   = cnt_q - 1'b1;
      end
      FIX: begin
        quot_d  = word_fix(fix_quot, word_q);
        rem_d   = word_fix(fix_rem, word_q);
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (flush_i && (state_q != IDLE)) begin
      state_d = IDLE;
      quot_d  = quot_q;
      rem_d   = rem_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      quot_q  <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
    end
  end

  always_ff @(posedge clk) begin
    dvd_q     <= dvd_d;
    dvs_q     <= dvs_d;
    sgn_q     <= sgn_d;
    word_q    <= word_d;
    qneg_q    <= qneg_d;
    rneg_q    <= rneg_d;
    dvs_abs_q <= dvs_abs_d;
    sr_q      <= sr_d;
    prem_q    <= prem_d;
    cnt_q     <= cnt_d;
  end

endmodule

// File: tb/tb_hp_int_div_rk.sv
// Bench for hp_int_div_rk: radix-2 and radix-16 instances driven with the same operations, scoreboard per instance.
module tb_hp_int_div_rk;

  logic        clk = 1'b0;
  logic        rst, flush_i, in_valid, signed_en, word_en;
  logic [63:0] dividend_i, divisor_i;
  logic        in_ready_1, in_ready_4, out_valid_1, out_valid_4, out_ready_1, out_ready_4;
  logic [63:0] quot_1, rem_1, quot_4, rem_4;

  always #5 clk = ~clk;

  hp_int_div_rk #(.XLEN(64), .RADIX_LOG2(1)) u_r1 (
    .clk(clk), .rst(rst), .flush_i(flush_i), .in_valid(in_valid), .in_ready(in_ready_1),
    .dividend_i(dividend_i), .divisor_i(divisor_i), .signed_en(signed_en), .word_en(word_en),
    .quot_o(quot_1), .rem_o(rem_1), .out_valid(out_valid_1), .out_ready(out_ready_1));

  hp_int_div_rk #(.XLEN(64), .RADIX_LOG2(4)) u_r4 (
    .clk(clk), .rst(rst), .flush_i(flush_i), .in_valid(in_valid), .in_ready(in_ready_4),
    .dividend_i(dividend_i), .divisor_i(divisor_i), .signed_en(signed_en), .word_en(word_en),
    .quot_o(quot_4), .rem_o(rem_4), .out_valid(out_valid_4), .out_ready(out_ready_4));

  typedef struct {
    logic [63:0] q;
    logic [63:0] r;
    int          lat;
  } exp_t;

  exp_t        sb1[$];
  exp_t        sb4[$];
  int          checks = 0;
  int          errors = 0;
  bit          c_vld = 1'b0;
  logic [63:0] c_a, c_b;
  logic        c_s, c_w;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // RISC-V reference semantics from native SV arithmetic
  function automatic void model(input logic [63:0] a, input logic [63:0] b, input logic s,
                                input logic w, output logic [63:0] q, output logic [63:0] r,
                                output bit special);
    logic [31:0] a32, b32, q32, r32;
    special = 1'b0;
    if (w) begin
      a32 = a[31:0];
      b32 = b[31:0];
      if (b32 == 32'd0) begin
        q32 = '1; r32 = a32; special = 1'b1;
      end else if (s && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) begin
        q32 = 32'h8000_0000; r32 = 32'd0; special = 1'b1;
      end else if (s) begin
        q32 = $signed(a32) / $signed(b32);
        r32 = $signed(a32) % $signed(b32);
      end else begin
        q32 = a32 / b32;
        r32 = a32 % b32;
      end
      q = {{32{q32[31]}}, q32};
      r = {{32{r32[31]}}, r32};
    end else begin
      if (b == 64'd0) begin
        q = '1; r = a; special = 1'b1;
      end else if (s && a == 64'h8000_0000_0000_0000 && b == '1) begin
        q = a; r = 64'd0; special = 1'b1;
      end else if (s) begin
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
      end else begin
        q = a / b;
        r = a % b;
      end
    end
  endfunction

  task automatic wait_ready();
    int n;
    n = 0;
    @(negedge clk);
    while (!(in_ready_1 && in_ready_4) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("in_ready_r1", 64'(in_ready_1), 64'd1);
    check("in_ready_r4", 64'(in_ready_4), 64'd1);
  endtask

  task automatic run_op(input logic [63:0] a, input logic [63:0] b, input logic s,
                        input logic w, input int hold);
    logic [63:0] eq, er, sq1, sr1, sq4, sr4;
    bit          special, hit, d1, d4, st1, st4, pend1, pend4;
    exp_t        e1, e4, g;
    int          cyc, h1, h4, lat1, lat4;
    model(a, b, s, w, eq, er, special);
    hit = c_vld && c_a == a && c_b == b && c_s == s && c_w == w;
`ifndef HP_DIV_RESULT_CACHE_EN
    hit = 1'b0;
`endif
    e1.q = eq; e1.r = er;
    e4.q = eq; e4.r = er;
    e1.lat = (special || hit) ? 2 : (w ? 32 : 64) / 1 + 3;
    e4.lat = (special || hit) ? 2 : (w ? 32 : 64) / 4 + 3;
    sb1.push_back(e1);
    sb4.push_back(e4);
    wait_ready();
    in_valid = 1'b1; dividend_i = a; divisor_i = b; signed_en = s; word_en = w;
    @(posedge clk);
    #1 in_valid = 1'b0;
    cyc = 1; d1 = 0; d4 = 0; h1 = 0; h4 = 0; st1 = 1; st4 = 1; pend1 = 0; pend4 = 0;
    lat1 = -1; lat4 = -1;
    @(negedge clk);
    check("busy_r1", 64'(in_ready_1), 64'd0);
    check("busy_r4", 64'(in_ready_4), 64'd0);
    while (!(d1 && d4) && cyc < 200) begin
      if (pend1) begin check("single_hs_r1", 64'(out_valid_1), 64'd0); pend1 = 0; end
      if (pend4) begin check("single_hs_r4", 64'(out_valid_4), 64'd0); pend4 = 0; end
      out_ready_1 = 1'b0;
      out_ready_4 = 1'b0;
      if (!d1 && out_valid_1) begin
        if (h1 == 0) begin lat1 = cyc; sq1 = quot_1; sr1 = rem_1; end
        else if (quot_1 !== sq1 || rem_1 !== sr1) st1 = 0;
        if (h1 >= hold) begin
          out_ready_1 = 1'b1; d1 = 1; pend1 = 1;
          g = sb1.pop_front();
          check("lat_r1", 64'(lat1), 64'(g.lat));
          check("quot_r1", quot_1, g.q);
          check("rem_r1", rem_1, g.r);
          if (hold > 0) check("stable_r1", 64'(st1), 64'd1);
        end
        h1++;
      end
      if (!d4 && out_valid_4) begin
        if (h4 == 0) begin lat4 = cyc; sq4 = quot_4; sr4 = rem_4; end
        else if (quot_4 !== sq4 || rem_4 !== sr4) st4 = 0;
        if (h4 >= hold) begin
          out_ready_4 = 1'b1; d4 = 1; pend4 = 1;
          g = sb4.pop_front();
          check("lat_r4", 64'(lat4), 64'(g.lat));
          check("quot_r4", quot_4, g.q);
          check("rem_r4", rem_4, g.r);
          if (hold > 0) check("stable_r4", 64'(st4), 64'd1);
        end
        h4++;
      end
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
    out_ready_1 = 1'b0;
    out_ready_4 = 1'b0;
    if (pend1) check("single_hs_r1", 64'(out_valid_1), 64'd0);
    if (pend4) check("single_hs_r4", 64'(out_valid_4), 64'd0);
    check("done_r1", 64'(d1), 64'd1);
    check("done_r4", 64'(d4), 64'd1);
    if (!d1) sb1.delete();
    if (!d4) sb4.delete();
    if (d1 && d4) begin
      c_vld = 1'b1; c_a = a; c_b = b; c_s = s; c_w = w;
    end
  endtask

  // start an operation and abandon it a few cycles into ITER
  task automatic start_op(input logic [63:0] a, input logic [63:0] b);
    wait_ready();
    in_valid = 1'b1; dividend_i = a; divisor_i = b; signed_en = 1'b0; word_en = 1'b0;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    bit seen;
    rst = 1'b1; flush_i = 1'b0; in_valid = 1'b0; signed_en = 1'b0; word_en = 1'b0;
    dividend_i = '0; divisor_i = '0; out_ready_1 = 1'b0; out_ready_4 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready_r1", 64'(in_ready_1), 64'd0);
    check("rst_in_ready_r4", 64'(in_ready_4), 64'd0);
    check("rst_out_valid_r1", 64'(out_valid_1), 64'd0);
    check("rst_out_valid_r4", 64'(out_valid_4), 64'd0);
    check("rst_quot_r1", quot_1, 64'd0);
    check("rst_rem_r1", rem_1, 64'd0);
    check("rst_quot_r4", quot_4, 64'd0);
    check("rst_rem_r4", rem_4, 64'd0);
    rst = 1'b0;

    run_op(-64'sd7, 64'd2, 1'b1, 1'b0, 0);
    run_op(64'd100, 64'd0, 1'b0, 1'b0, 0);
    run_op(64'h8000_0000_0000_0000, '1, 1'b1, 1'b0, 0);
    run_op(64'h1_8000_0000, 64'hFFFF_FFFF, 1'b1, 1'b1, 0);
    run_op(64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0, 1'b1, 0);
    run_op(-64'sd100, 64'd7, 1'b1, 1'b1, 0);
    run_op(64'd100, -64'sd7, 1'b1, 1'b0, 0);
    run_op(64'h0000_0000_8000_0005, 64'h1_0000_0000, 1'b0, 1'b1, 0);
    run_op(64'd12345678901, 64'd98765, 1'b0, 1'b0, 5);

    start_op(64'd500, 64'd9);
    flush_i = 1'b1;
    @(posedge clk);
    #1 flush_i = 1'b0;
    @(negedge clk);
    check("flush_in_ready_r1", 64'(in_ready_1), 64'd1);
    check("flush_in_ready_r4", 64'(in_ready_4), 64'd1);
    seen = 1'b0;
    repeat (80) begin
      @(negedge clk);
      if (out_valid_1 || out_valid_4) seen = 1'b1;
    end
    check("flush_no_out", 64'(seen), 64'd0);
    run_op(64'd500, 64'd9, 1'b0, 1'b0, 0);

    run_op(64'd1000, 64'd7, 1'b0, 1'b0, 0);
    run_op(64'd1000, 64'd7, 1'b0, 1'b0, 0);

    start_op(64'd1000, 64'd7);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_in_ready_r1", 64'(in_ready_1), 64'd0);
    rst = 1'b0;
    c_vld = 1'b0;
    check("midrst_out_valid_r1", 64'(out_valid_1), 64'd0);
    check("midrst_quot_r1", quot_1, 64'd0);
    check("midrst_rem_r4", rem_4, 64'd0);
    run_op(64'd1000, 64'd7, 1'b0, 1'b0, 0);
    run_op(64'd1000, 64'd7, 1'b0, 1'b0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
